// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler: round-robin enemy return fire.
// Picks a living ship each period and launches into a free laser slot.
module enemy_fire_scheduler #(
  parameter int NUM_SHIPS   = 18,
  parameter int FIRE_PERIOD = 45,
  parameter int IDX_W       = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic                 play,
  input  logic [NUM_SHIPS-1:0] alive,
  input  logic [1:0]           slot_busy,
  output logic                 fire_valid,
  output logic                 fire_slot,
  output logic [IDX_W-1:0]     fire_idx,
  output logic [7:0]           shot_count
);

  localparam int CNT_W =
    (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] RELOAD =
    CNT_W'(FIRE_PERIOD - 1);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_SHIPS - 1);
  localparam logic [IDX_W:0] NSHIP =
    (IDX_W+1)'(NUM_SHIPS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SCAN,
    LAUNCH
  } state_t;

  state_t           state_q, state_d;
  logic             frame_q, frame_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0] tgt_q, tgt_d;
  logic             fire_valid_q, fire_valid_d;
  logic             fire_slot_q, fire_slot_d;
  logic [IDX_W-1:0] fire_idx_q, fire_idx_d;
  logic [7:0]       shot_count_q, shot_count_d;

  logic             tick;
  logic [IDX_W:0]   cand_sum;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] next_ptr;
  logic [7:0]       shot_inc;

  // Candidate index, frame edge detect and post-launch pointer.
  always_comb begin
    tick     = frame_clk & ~frame_q;
    cand_sum = {1'b0, ptr_q} + {1'b0, scan_cnt_q};
    cand     = IDX_W'((cand_sum >= NSHIP) ?
                      cand_sum - NSHIP : cand_sum);
    next_ptr = (tgt_q == LAST) ? '0 : tgt_q + 1'b1;
    shot_inc = (shot_count_q == 8'hFF) ?
               shot_count_q : shot_count_q + 8'd1;
  end

  // Next-state logic: period countdown, scan, slot arbitration.
  always_comb begin
    state_d      = state_q;
    frame_d      = frame_clk;
    frame_cnt_d  = frame_cnt_q;
    ptr_d        = ptr_q;
    scan_cnt_d   = scan_cnt_q;
    tgt_d        = tgt_q;
    fire_valid_d = 1'b0;
    fire_slot_d  = fire_slot_q;
    fire_idx_d   = fire_idx_q;
    shot_count_d = shot_count_q;
    if (!play) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          frame_cnt_d = RELOAD;
          state_d     = WAIT;
        end
        WAIT: begin
          if (tick) begin
            if (frame_cnt_q == '0) begin
              scan_cnt_d = '0;
              state_d    = SCAN;
            end else begin
              frame_cnt_d = frame_cnt_q - 1'b1;
            end
          end
        end
        SCAN: begin
          if (alive[cand]) begin
            tgt_d   = cand;
            state_d = LAUNCH;
          end else if (scan_cnt_q == LAST) begin
            frame_cnt_d = RELOAD;
            state_d     = WAIT;
          end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
          end
        end
        LAUNCH: begin
          if (!alive[tgt_q]) begin
            scan_cnt_d = '0;
            state_d    = SCAN;
          end else if (!(&slot_busy)) begin
            fire_valid_d = 1'b1;
            fire_slot_d  = slot_busy[0];
            fire_idx_d   = tgt_q;
            ptr_d        = next_ptr;
            shot_count_d = shot_inc;
            frame_cnt_d  = RELOAD;
            state_d      = WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      frame_q      <= 1'b0;
      frame_cnt_q  <= '0;
      ptr_q        <= '0;
      scan_cnt_q   <= '0;
      tgt_q        <= '0;
      fire_valid_q <= 1'b0;
      fire_slot_q  <= 1'b0;
      fire_idx_q   <= '0;
      shot_count_q <= '0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      frame_cnt_q  <= frame_cnt_d;
      ptr_q        <= ptr_d;
      scan_cnt_q   <= scan_cnt_d;
      tgt_q        <= tgt_d;
      fire_valid_q <= fire_valid_d;
      fire_slot_q  <= fire_slot_d;
      fire_idx_q   <= fire_idx_d;
      shot_count_q <= shot_count_d;
    end
  end

  assign fire_valid = fire_valid_q;
  assign fire_slot  = fire_slot_q;
  assign fire_idx   = fire_idx_q;
  assign shot_count = shot_count_q;

endmodule

// File: doc/enemy_fire_scheduler.md
# enemy_fire_scheduler

Sequences enemy return fire during the play state. Every FIRE_PERIOD frames it picks one living enemy ship from the 18-ship formation (3 rows × 6) in round-robin order. It then launches that ship's shot into one of two shared enemy-laser slots. It sits beside the three enemy-ship rows and the enemy laser units inside the game controller, and it is driven by the play flag from the signal controller.

## Interface
Parameters:
- NUM_SHIPS, 18, formation size; ship index = (row-1)*6 + (col-1), so row1 is 0..5, row2 is 6..11, row3 is 12..17
- FIRE_PERIOD, 45, frame_clk rising edges between shot attempts (must be ≥1)
- IDX_W, 5, width of a ship index

Ports:
- Clk  in  1  system clock (50 MHz); all logic on its rising edge
- Reset  in  1  synchronous, active-high; has priority over every other input
- frame_clk  in  1  ~60 Hz frame strobe; sampled on Clk, and only its rising edge counts
- play  in  1  game is in the play state
- alive  in  NUM_SHIPS  bit i high = ship i still on screen
- slot_busy  in  2  bit k high = enemy laser slot k is in flight
- fire_valid  out  1  one-Clk launch pulse (registered)
- fire_slot  out  1  slot being launched; valid with fire_valid
- fire_idx  out  IDX_W  shooting ship index; valid with fire_valid
- shot_count  out  8  total shots launched, saturating at 255

## Operation
- Frame tick: frame_q <= frame_clk; tick = frame_clk & ~frame_q.
- Registers: state, frame_cnt (period countdown), ptr (round-robin start index), scan_cnt (candidates examined).
- States and transitions:
  - IDLE: outputs quiet. When play=1, frame_cnt <= FIRE_PERIOD-1 and go to WAIT.
  - WAIT: on each tick, frame_cnt decrements. On a tick with frame_cnt==0, scan_cnt <= 0 and go to SCAN.
  - SCAN: examines one candidate per Clk, cand = (ptr + scan_cnt) mod NUM_SHIPS.
    - If alive[cand]=1, latch fire_idx <= cand and go to LAUNCH.
    - Otherwise scan_cnt increments.
    - If scan_cnt==NUM_SHIPS-1 with no hit, reload frame_cnt and go to WAIT with no shot.
  - LAUNCH:
    - If alive[fire_idx]=0 (ship killed while waiting), scan_cnt <= 0 and go to SCAN from the unchanged ptr.
    - Else if slot_busy[0]=0, fire slot 0.
    - Else if slot_busy[1]=0, fire slot 1.
    - Else both slots are busy: hold in LAUNCH indefinitely.
    - Firing: fire_valid <= 1, fire_slot <= chosen slot, ptr <= (fire_idx+1) wrapped at NUM_SHIPS, shot_count <= shot_count+1 unless already 255, reload frame_cnt, go to WAIT.
- play=0 in any state: next state is IDLE, fire_valid <= 0, and no launch occurs that cycle, even if LAUNCH had a free slot. ptr and shot_count are retained.
- Slot choice is fixed priority: slot 0 over slot 1.
- Index arithmetic is modulo NUM_SHIPS and never produces an index ≥ NUM_SHIPS.

## Timing
- Reset values: state=IDLE, fire_valid=0, fire_slot=0, fire_idx=0, shot_count=0, ptr=0, frame_cnt=0, scan_cnt=0, frame_q=0.
- fire_valid is high for exactly one Clk, in the first WAIT cycle after LAUNCH.
- fire_idx and fire_slot hold their values until the next launch.
- Latency from period expiry:
  - The tick edge enters SCAN.
  - If cand(ptr) is alive: LAUNCH on the next edge, fire_valid on the edge after. That is 2 Clk after SCAN entry.
  - Each dead ship skipped adds 1 Clk; worst case with a free slot is NUM_SHIPS+1 Clk.
- Fire interval: at most one shot per FIRE_PERIOD ticks. The period countdown restarts on the launch or failed-scan edge, not on the expiry tick.
- alive and slot_busy are sampled combinationally in the cycle of use; no extra latency.
- Reset mid-SCAN or mid-LAUNCH: no pulse is issued and the block returns to IDLE on that edge.

## Test plan
- Reset, play=1, all alive, slots free, FIRE_PERIOD=3, pulse frame_clk 3 times → fire_valid one pulse with fire_idx=0, fire_slot=0, shot_count=1. The next period gives fire_idx=1.
- alive=18'h3FFF8 (ships 0–2 dead), ptr=0 → fire_idx=3, and fire_valid arrives 5 Clk after SCAN entry.
- alive=0 → a full 18-candidate scan, no fire_valid, return to WAIT, shot_count unchanged.
- slot_busy=2'b01 → fire_slot=1. With slot_busy=2'b11, the block holds in LAUNCH with no pulse. Dropping slot_busy[0] gives a launch on slot 0 within 2 Clk.
- Block held in LAUNCH on ship 7, then alive[7] cleared → rescan from ptr, and the launch goes to the next alive index (8 if alive).
- Deassert play in LAUNCH with a free slot → no pulse, IDLE next cycle. Force shot_count to 255 and launch → count stays 255.
